cpu_multicycle: RTL

Multi-cycle successor to the single-cycle MIPS-subset core. It executes the same instruction subset over a shared FETCH/DECODE/EXEC/MEM/WB state machine. Instruction and data traffic go through one unified memory port with a req/ack handshake, so any memory latency is tolerated. It adds a configurable reset vector, fault trapping with a sticky halt, and a retired-instruction counter. It sits at the top of the design between the testbench/SoC memory and the existing `alu` and `regfile`.

---
 rtl/cpu_pkg.sv | 79 +++++++
 rtl/alu.sv | 34 +++
 rtl/cpu_mc_control.sv | 154 +++++++++++++++
 rtl/regfile.sv | 22 ++
 rtl/cpu_multicycle.sv | 128 ++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the multi-cycle MIPS-subset core.
// Opcodes, FSM states, trap codes, ALU commands and control bundle.
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    TRAP_NONE,
    TRAP_ILL,
    TRAP_OVF,
    TRAP_MIS
  } trap_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_SLT
  } alu_cmd_e;

  typedef enum logic [1:0] {
    PC_INC,
    PC_BR,
    PC_JMP,
    PC_REG
  } pc_sel_e;

  typedef enum logic [1:0] {
    WA_RD,
    WA_RT,
    WA_R31
  } wa_sel_e;

  typedef enum logic [1:0] {
    WD_ALU,
    WD_MDR,
    WD_PC
  } wd_sel_e;

  typedef struct packed {
    logic     mem_req;
    logic     mem_we;
    logic     addr_alu;
    logic     ir_we;
    logic     ab_we;
    logic     alu_out_we;
    logic     mdr_we;
    logic     pc_we;
    pc_sel_e  pc_sel;
    logic     rf_we;
    wa_sel_e  wa_sel;
    wd_sel_e  wd_sel;
    alu_cmd_e alu_cmd;
    logic     alu_imm;
    logic     imm_zext;
    logic     retire;
  } ctrl_t;
endpackage

// File: rtl/alu.sv
// alu: 32-bit add/sub/xor/slt with signed overflow flag.
// Overflow is reported for add and sub; the caller decides if it traps.
module alu import cpu_pkg::*; (
  input  alu_cmd_e    cmd_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o,
  output logic        ovf_o
);
  logic [31:0] sum;
  logic [31:0] dif;

  assign sum = a_i + b_i;
  assign dif = a_i - b_i;

  // Result and overflow select
  always_comb begin
    y_o   = sum;
    ovf_o = 1'b0;
    unique case (cmd_i)
      ALU_ADD: begin
        y_o   = sum;
        ovf_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
      end
      ALU_SUB: begin
        y_o   = dif;
        ovf_o = (a_i[31] != b_i[31]) && (dif[31] != a_i[31]);
      end
      ALU_XOR: y_o = a_i ^ b_i;
      ALU_SLT: y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu_mc_control.sv
// cpu_mc_control: FSM and instruction decode for the multi-cycle core.
// Produces the per-cycle control bundle and holds the trap cause.
module cpu_mc_control import cpu_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_i,
  input  logic [5:0] fn_i,
  input  logic       mem_ack_i,
  input  logic       alu_ovf_i,
  input  logic [1:0] alu_lsb_i,
  input  logic [1:0] rs_lsb_i,
  input  logic       ne_i,
  output ctrl_t      ctrl_o,
  output logic       halted_o,
  output trap_e      cause_o
);
  state_e state_q, state_d;
  trap_e  cause_q, cause_d;

  logic is_r, is_add, is_sub, is_slt, is_jr;
  logic is_j, is_jal, is_bne, is_addi, is_xori;
  logic is_lw, is_sw, legal, ovf_op;

  assign is_r    = (op_i == OP_RTYPE);
  assign is_add  = is_r && (fn_i == FN_ADD);
  assign is_sub  = is_r && (fn_i == FN_SUB);
  assign is_slt  = is_r && (fn_i == FN_SLT);
  assign is_jr   = is_r && (fn_i == FN_JR);
  assign is_j    = (op_i == OP_J);
  assign is_jal  = (op_i == OP_JAL);
  assign is_bne  = (op_i == OP_BNE);
  assign is_addi = (op_i == OP_ADDI);
  assign is_xori = (op_i == OP_XORI);
  assign is_lw   = (op_i == OP_LW);
  assign is_sw   = (op_i == OP_SW);
  assign ovf_op  = is_add | is_sub | is_addi;
  assign legal   = is_add | is_sub | is_slt | is_jr
                 | is_j | is_jal | is_bne | is_addi
                 | is_xori | is_lw | is_sw;

  assign halted_o = (state_q == S_HALT);
  assign cause_o  = cause_q;

  // State and trap cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_START;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next state and control bundle
  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    ctrl_o           = '0;
    ctrl_o.alu_imm   = !is_r;
    ctrl_o.imm_zext  = is_xori;
    ctrl_o.wa_sel    = is_r ? WA_RD : WA_RT;
    ctrl_o.wd_sel    = is_lw ? WD_MDR : WD_ALU;
    unique case (1'b1)
      is_sub:  ctrl_o.alu_cmd = ALU_SUB;
      is_slt:  ctrl_o.alu_cmd = ALU_SLT;
      is_xori: ctrl_o.alu_cmd = ALU_XOR;
      default: ctrl_o.alu_cmd = ALU_ADD;
    endcase
    unique case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        if (mem_ack_i) begin
          ctrl_o.ir_we  = 1'b1;
          ctrl_o.pc_we  = 1'b1;
          ctrl_o.pc_sel = PC_INC;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_o.ab_we = 1'b1;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          cause_d = TRAP_ILL;
        end
      end
      S_EXEC: begin
        ctrl_o.alu_out_we = 1'b1;
        state_d           = S_FETCH;
        unique case (1'b1)
          is_j, is_jal: begin
            ctrl_o.pc_we  = 1'b1;
            ctrl_o.pc_sel = PC_JMP;
            ctrl_o.rf_we  = is_jal;
            ctrl_o.wa_sel = WA_R31;
            ctrl_o.wd_sel = WD_PC;
            ctrl_o.retire = 1'b1;
          end
          is_bne: begin
            ctrl_o.pc_we  = ne_i;
            ctrl_o.pc_sel = PC_BR;
            ctrl_o.retire = 1'b1;
          end
          is_jr: begin
            if (rs_lsb_i != 2'd0) begin
              state_d = S_HALT;
              cause_d = TRAP_MIS;
            end else begin
              ctrl_o.pc_we  = 1'b1;
              ctrl_o.pc_sel = PC_REG;
              ctrl_o.retire = 1'b1;
            end
          end
          is_lw, is_sw: begin
            if (alu_lsb_i != 2'd0) begin
              state_d = S_HALT;
              cause_d = TRAP_MIS;
            end else begin
              state_d = S_MEM;
            end
          end
          default: begin
            if (ovf_op && alu_ovf_i) begin
              state_d = S_HALT;
              cause_d = TRAP_OVF;
            end else begin
              state_d = S_WB;
            end
          end
        endcase
      end
      S_MEM: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.mem_we   = is_sw;
        ctrl_o.addr_alu = 1'b1;
        if (mem_ack_i) begin
          ctrl_o.mdr_we = is_lw;
          ctrl_o.retire = is_sw;
          state_d       = is_sw ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        ctrl_o.rf_we  = 1'b1;
        ctrl_o.retire = 1'b1;
        state_d       = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_START;
    endcase
  end
endmodule

// File: rtl/regfile.sv
// regfile: 32 x 32 register file, two read ports, one write port.
// r0 is hardwired to zero; writes to it are dropped.
module regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] rf_q [32];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we_i && (wa_i != 5'd0)) rf_q[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : rf_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : rf_q[ra2_i];
endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle MIPS-subset core on one memory port.
// Holds pc, IR, operand/data latches and the retired counter.
module cpu_multicycle import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);
  ctrl_t ctrl;
  trap_e cause;

  logic [31:0] pc_q, pc_d, ir_q, a_q, b_q;
  logic [31:0] alu_out_q, mdr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] rd1, rd2, imm_s, imm_z;
  logic [31:0] br_off, alu_b, alu_y, rf_wd;
  logic [4:0]  rf_wa;
  logic        alu_ovf;

  assign imm_s  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign imm_z  = {16'd0, ir_q[15:0]};
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign alu_b  = !ctrl.alu_imm ? b_q
                : (ctrl.imm_zext ? imm_z : imm_s);

  cpu_mc_control u_ctrl (
    .clk       (clk),
    .rst       (reset),
    .op_i      (ir_q[31:26]),
    .fn_i      (ir_q[5:0]),
    .mem_ack_i (mem_ack),
    .alu_ovf_i (alu_ovf),
    .alu_lsb_i (alu_y[1:0]),
    .rs_lsb_i  (a_q[1:0]),
    .ne_i      (a_q != b_q),
    .ctrl_o    (ctrl),
    .halted_o  (halted),
    .cause_o   (cause)
  );

  regfile u_rf (
    .clk   (clk),
    .we_i  (ctrl.rf_we),
    .ra1_i (ir_q[25:21]),
    .ra2_i (ir_q[20:16]),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  alu u_alu (
    .cmd_i (ctrl.alu_cmd),
    .a_i   (a_q),
    .b_i   (alu_b),
    .y_o   (alu_y),
    .ovf_o (alu_ovf)
  );

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign mem_addr   = ctrl.addr_alu ? alu_out_q : pc_q;
  assign mem_wdata  = b_q;
  assign trap_cause = cause;
  assign retired    = cnt_q;

  // Next pc source
  always_comb begin
    pc_d = pc_q + 32'd4;
    unique case (ctrl.pc_sel)
      PC_INC:  pc_d = pc_q + 32'd4;
      PC_BR:   pc_d = pc_q + br_off;
      PC_JMP:  pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      PC_REG:  pc_d = a_q;
      default: ;
    endcase
  end

  // Register write address and data select
  always_comb begin
    rf_wa = ir_q[15:11];
    rf_wd = alu_out_q;
    unique case (ctrl.wa_sel)
      WA_RD:   rf_wa = ir_q[15:11];
      WA_RT:   rf_wa = ir_q[20:16];
      WA_R31:  rf_wa = 5'd31;
      default: ;
    endcase
    unique case (ctrl.wd_sel)
      WD_ALU:  rf_wd = alu_out_q;
      WD_MDR:  rf_wd = mdr_q;
      WD_PC:   rf_wd = pc_q;
      default: ;
    endcase
  end

  // Datapath latches and retired counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      alu_out_q <= 32'd0;
      mdr_q     <= 32'd0;
      cnt_q     <= '0;
    end else begin
      if (ctrl.pc_we)      pc_q      <= pc_d;
      if (ctrl.ir_we)      ir_q      <= mem_rdata;
      if (ctrl.ab_we)      a_q       <= rd1;
      if (ctrl.ab_we)      b_q       <= rd2;
      if (ctrl.alu_out_we) alu_out_q <= alu_y;
      if (ctrl.mdr_we)     mdr_q     <= mem_rdata;
      if (ctrl.retire)
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule
